// File: rtl/sddac_interp_upsampler_pkg.sv
// Shared types, widths and default parameters for the sigma-delta DAC interpolating upsampler.
// The default ratio and divider macros can be overridden from the command line or a globals header.
`ifndef SDDAC_INTERP_RATIO_LOG2
`define SDDAC_INTERP_RATIO_LOG2 3
`endif
`ifndef SDDAC_INTERP_OUT_DIV
`define SDDAC_INTERP_OUT_DIV 64
`endif

package sddac_interp_upsampler_pkg;

  localparam int SAMPLE_W       = 18;
  localparam int DIFF_W         = SAMPLE_W + 1;
  localparam int DEF_RATIO_LOG2 = `SDDAC_INTERP_RATIO_LOG2;
  localparam int DEF_OUT_DIV    = `SDDAC_INTERP_OUT_DIV;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [DIFF_W-1:0]   diff_t;

  // One extra bit keeps the full-scale swing between two samples exact.
  function automatic diff_t seg_diff(input sample_t new_cur, input sample_t old_cur);
    diff_t n_s;
    diff_t o_s;
    n_s = {new_cur[SAMPLE_W-1], new_cur};
    o_s = {old_cur[SAMPLE_W-1], old_cur};
    return n_s - o_s;
  endfunction

endpackage

// File: rtl/sddac_interp_channel.sv
// Per-channel interpolation datapath: pending/cur/prev samples, slope accumulator and output register.
// Shared timing (tick, wrap, pending-valid) comes from the upsampler top.
module sddac_interp_channel
  import sddac_interp_upsampler_pkg::*;
#(
  parameter int RATIO_LOG2 = DEF_RATIO_LOG2
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t sample_in_i,
  input  logic    strobe_i,
  input  logic    pv_i,
  input  logic    tick_i,
  input  logic    wrap_i,
  output sample_t sample_out_o
);

  localparam int ACC_W = DIFF_W + RATIO_LOG2;

  sample_t prev_q, prev_d;
  sample_t cur_q, cur_d;
  sample_t pending_q, pending_d;
  sample_t out_q, out_d;
  sample_t new_cur_s;
  diff_t   diff_q, diff_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // A strobe landing on the wrap cycle bypasses pending straight into cur.
  always_comb begin
    if (strobe_i) begin
      new_cur_s = sample_in_i;
    end else if (pv_i) begin
      new_cur_s = pending_q;
    end else begin
      new_cur_s = cur_q;
    end
  end

  always_comb begin
    prev_d    = prev_q;
    cur_d     = cur_q;
    pending_d = pending_q;
    acc_d     = acc_q;
    diff_d    = diff_q;
    out_d     = out_q;
    if (strobe_i) begin
      pending_d = sample_in_i;
    end else begin
      pending_d = pending_q;
    end
    if (tick_i) begin
      out_d = acc_q[RATIO_LOG2 +: SAMPLE_W];
      if (wrap_i) begin
        prev_d = cur_q;
        cur_d  = new_cur_s;
        acc_d  = {prev_d[SAMPLE_W-1], prev_d, {RATIO_LOG2{1'b0}}};
        diff_d = seg_diff(new_cur_s, prev_d);
      end else begin
        acc_d = acc_q + {{RATIO_LOG2{diff_q[DIFF_W-1]}}, diff_q};
      end
    end else begin
      out_d = out_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      cur_q     <= '0;
      pending_q <= '0;
      acc_q     <= '0;
      diff_q    <= '0;
      out_q     <= '0;
    end else begin
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
      diff_q    <= diff_d;
      out_q     <= out_d;
    end
  end

  assign sample_out_o = out_q;

endmodule

// File: rtl/sddac_interp_upsampler.sv
// Stereo linear-interpolation upsampler feeding the sigma-delta DAC: output divider, phase counter,
// request/strobe handshake and sticky underrun/overrun flags around two channel datapaths.
module sddac_interp_upsampler
  import sddac_interp_upsampler_pkg::*;
#(
  parameter int RATIO_LOG2 = DEF_RATIO_LOG2,
  parameter int OUT_DIV    = DEF_OUT_DIV
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t sample_in_l,
  input  sample_t sample_in_r,
  input  logic    sample_in_rdy,
  output logic    sample_req,
  output sample_t sample_out_l,
  output sample_t sample_out_r,
  output logic    sample_out_rdy,
  output logic    underrun,
  output logic    overrun
);

  localparam int DIV_W = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(OUT_DIV - 1);
  localparam logic [RATIO_LOG2-1:0] K_LAST   = {RATIO_LOG2{1'b1}};

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [RATIO_LOG2-1:0] k_q, k_d;
  logic pv_q, pv_d;
  logic started_q, started_d;
  logic req_q, req_d;
  logic rdy_q, rdy_d;
  logic underrun_q, underrun_d;
  logic overrun_q, overrun_d;
  logic tick_s, wrap_s;

  assign tick_s = (div_cnt_q == DIV_LAST);
  assign wrap_s = tick_s && (k_q == K_LAST);

  // started_q gives the single request on the first clock after reset release.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    k_d        = k_q;
    pv_d       = pv_q;
    started_d  = 1'b1;
    req_d      = wrap_s | ~started_q;
    rdy_d      = tick_s;
    overrun_d  = overrun_q | (sample_in_rdy & pv_q);
    underrun_d = underrun_q | (wrap_s & ~sample_in_rdy & ~pv_q);
    if (tick_s) begin
      div_cnt_d = '0;
      if (wrap_s) begin
        k_d = '0;
      end else begin
        k_d = k_q + RATIO_LOG2'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    if (wrap_s) begin
      pv_d = 1'b0;
    end else if (sample_in_rdy) begin
      pv_d = 1'b1;
    end else begin
      pv_d = pv_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      k_q        <= '0;
      pv_q       <= 1'b0;
      started_q  <= 1'b0;
      req_q      <= 1'b0;
      rdy_q      <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      k_q        <= k_d;
      pv_q       <= pv_d;
      started_q  <= started_d;
      req_q      <= req_d;
      rdy_q      <= rdy_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  sddac_interp_channel #(.RATIO_LOG2(RATIO_LOG2)) u_chan_l (
    .clk          (clk),
    .reset        (reset),
    .sample_in_i  (sample_in_l),
    .strobe_i     (sample_in_rdy),
    .pv_i         (pv_q),
    .tick_i       (tick_s),
    .wrap_i       (wrap_s),
    .sample_out_o (sample_out_l)
  );

  sddac_interp_channel #(.RATIO_LOG2(RATIO_LOG2)) u_chan_r (
    .clk          (clk),
    .reset        (reset),
    .sample_in_i  (sample_in_r),
    .strobe_i     (sample_in_rdy),
    .pv_i         (pv_q),
    .tick_i       (tick_s),
    .wrap_i       (wrap_s),
    .sample_out_o (sample_out_r)
  );

  assign sample_req     = req_q;
  assign sample_out_rdy = rdy_q;
  assign underrun       = underrun_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_sddac_interp_upsampler.sv
// Scoreboard bench for sddac_interp_upsampler: a segment-level reference model predicts every
// output sample and flag; a monitor pops predictions whenever the DUT strobes sample_out_rdy.
module tb_sddac_interp_upsampler;

  localparam int RL2     = 3;
  localparam int R       = 8;
  localparam int OUT_DIV = 64;
  localparam int SEG     = R * OUT_DIV;
  localparam int MAXC    = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [17:0] sample_in_l = 18'sd0;
  logic signed [17:0] sample_in_r = 18'sd0;
  logic sample_in_rdy = 1'b0;
  logic sample_req;
  logic signed [17:0] sample_out_l;
  logic signed [17:0] sample_out_r;
  logic sample_out_rdy;
  logic underrun;
  logic overrun;

  sddac_interp_upsampler #(.RATIO_LOG2(RL2), .OUT_DIV(OUT_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in_l    (sample_in_l),
    .sample_in_r    (sample_in_r),
    .sample_in_rdy  (sample_in_rdy),
    .sample_req     (sample_req),
    .sample_out_l   (sample_out_l),
    .sample_out_r   (sample_out_r),
    .sample_out_rdy (sample_out_rdy),
    .underrun       (underrun),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit ev_v[MAXC];
  int ev_l[MAXC];
  int ev_r[MAXC];
  int log_l[128];
  int log_r[128];
  int out_idx = 0;

  // reference-model state: segment endpoints, pending sample, flags
  int pl, cl, pr, cr, pend_l, pend_r;
  bit pv, und, ovr;

  function automatic int s18(input int x);
    int m;
    m = x & 32'h0003_FFFF;
    return (m >= 131072) ? m - 262144 : m;
  endfunction

  // P + floor(k*(C-P)/R) with true floor toward minus infinity
  function automatic int interp(input int p, input int c, input int k);
    int num;
    int qt;
    num = k * (c - p);
    if (num >= 0) qt = num / R;
    else qt = -((-num + R - 1) / R);
    return p + qt;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sample_out_rdy) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy_unexpected: sample_out_rdy=1 expected=0");
      end else begin
        e = q.pop_front();
        chk("out_l", s18(int'(sample_out_l)), e.l);
        chk("out_r", s18(int'(sample_out_r)), e.r);
        if (out_idx < 128) begin
          log_l[out_idx] = s18(int'(sample_out_l));
          log_r[out_idx] = s18(int'(sample_out_r));
        end
        out_idx++;
      end
    end
  end

  task automatic clear_events();
    for (int i = 0; i < MAXC; i++) begin
      ev_v[i] = 1'b0;
      ev_l[i] = 0;
      ev_r[i] = 0;
    end
  endtask

  task automatic add_ev(input int c, input int l, input int r);
    ev_v[c] = 1'b1;
    ev_l[c] = s18(l);
    ev_r[c] = s18(r);
  endtask

  task automatic gen_random(input int s0, input int s1);
    int mode;
    int b;
    for (int s = s0; s < s1; s++) begin
      b = s * SEG;
      mode = int'($urandom_range(0, 5));
      if (mode == 1) begin
        add_ev(b + int'($urandom_range(0, 250)), int'($urandom), int'($urandom));
        add_ev(b + int'($urandom_range(260, 510)), int'($urandom), int'($urandom));
      end else if (mode == 2) begin
        add_ev(b + SEG - 1, int'($urandom), int'($urandom));
      end else if (mode >= 3) begin
        add_ev(b + int'($urandom_range(0, SEG - 1)), int'($urandom), int'($urandom));
      end
    end
  endtask

  // Release reset, run n cycles against the model, then reset again and check the cleared state.
  task automatic run(input int n, input int tag);
    bit prev_wrap;
    bit strobe;
    bit tick;
    int k;
    int ncl, ncr;
    exp_t e;
    pl = 0; cl = 0; pr = 0; cr = 0; pend_l = 0; pend_r = 0;
    pv = 1'b0; und = 1'b0; ovr = 1'b0;
    prev_wrap = 1'b0;
    out_idx = 0;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk("sample_req", int'(sample_req), int'((c == 1) || prev_wrap));
      chk("underrun", int'(underrun), int'(und));
      chk("overrun", int'(overrun), int'(ovr));
      if (tag == 3 && c == SEG) chk("wrap_strobe_no_underrun", int'(underrun), 0);
      strobe = ev_v[c];
      sample_in_rdy = strobe;
      sample_in_l = strobe ? 18'(ev_l[c]) : 18'($urandom);
      sample_in_r = strobe ? 18'(ev_r[c]) : 18'($urandom);
      tick = ((c % OUT_DIV) == OUT_DIV - 1);
      k = (c / OUT_DIV) % R;
      prev_wrap = tick && (k == R - 1);
      if (tick) begin
        chk("missed_rdy_backlog", q.size(), 0);
        e.l = interp(pl, cl, k);
        e.r = interp(pr, cr, k);
        q.push_back(e);
      end
      if (prev_wrap) begin
        if (strobe) begin
          if (pv) ovr = 1'b1;
          ncl = ev_l[c];
          ncr = ev_r[c];
        end else if (pv) begin
          ncl = pend_l;
          ncr = pend_r;
        end else begin
          und = 1'b1;
          ncl = cl;
          ncr = cr;
        end
        pl = cl; pr = cr;
        cl = ncl; cr = ncr;
        pv = 1'b0;
      end else if (strobe) begin
        if (pv) ovr = 1'b1;
        pend_l = ev_l[c];
        pend_r = ev_r[c];
        pv = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    sample_in_rdy = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_out_l", int'(sample_out_l), 0);
    chk("rst_out_r", int'(sample_out_r), 0);
    chk("rst_out_rdy", int'(sample_out_rdy), 0);
    chk("rst_req", int'(sample_req), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int fl[8];
    fl[0] = 0; fl[1] = -2; fl[2] = -3; fl[3] = -4;
    fl[4] = -5; fl[5] = -6; fl[6] = -7; fl[7] = -8;
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_l", int'(sample_out_l), 0);
    chk("init_req", int'(sample_req), 0);
    chk("init_underrun", int'(underrun), 0);

    // idle: request at cycle 1, zero outputs, underrun at first wrap
    clear_events();
    run(2 * SEG + 10, 1);
    for (int i = 0; i < 16; i++) chk("idle_l", log_l[i], 0);

    // ramp, hold, floor rounding, overrun, strobe on wrap, random, reset at k=4
    clear_events();
    add_ev(5, 32'h0000_0800, 32'h0003_F800);
    add_ev(2 * SEG + 10, 0, 0);
    add_ev(3 * SEG + 10, 32'h0003_FFF7, 0);
    add_ev(4 * SEG + 20, 32'h0000_1000, 1);
    add_ev(4 * SEG + 40, 32'h0000_2000, 2);
    add_ev(6 * SEG - 1, 32'h0000_3000, 32'h0003_D000);
    gen_random(6, 14);
    run(14 * SEG + 4 * OUT_DIV + 10, 2);
    for (int k = 0; k < R; k++) begin
      chk("ramp_l", log_l[8 + k], 256 * k);
      chk("ramp_r", log_r[8 + k], -256 * k);
      chk("hold_l", log_l[16 + k], 2048);
      chk("hold_r", log_r[16 + k], -2048);
      chk("floor_l", log_l[32 + k], fl[k]);
    end

    // restart after reset; strobe exactly on the first wrap tick
    clear_events();
    add_ev(SEG - 1, 32'h0000_3000, 32'h0003_D000);
    gen_random(1, 4);
    run(4 * SEG + 10, 3);
    for (int k = 0; k < R; k++) chk("wrap_strobe_l", log_l[8 + k], 1536 * k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sddac_interp_upsampler.md
# sddac_interp_upsampler

Stereo linear-interpolation upsampler that sits directly upstream of the second-order sigma-delta DAC. It accepts 18-bit signed stereo samples at the audio rate through a request/strobe handshake. It emits 2^RATIO_LOG2 linearly interpolated samples per input, one every OUT_DIV clocks, on the DAC's `sample_in_l/r` / `sample_in_rdy` interface. Each output's position between two input samples depends only on the phase counter, not on when the input arrives. Underrun and overrun are flagged as sticky status bits.

## Interface
- RATIO_LOG2, 3 — log2 of the upsampling ratio R (R = 8).
- OUT_DIV, 64 — clocks per output sample; legal values 8..4096.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sample_in_l, sample_in_r  in  18 each  signed input samples.
- sample_in_rdy  in  1  one-cycle strobe; input samples are valid in this cycle.
- sample_req  out  1  one-cycle pulse requesting the next input sample.
- sample_out_l, sample_out_r  out  18 each  signed, registered interpolated samples (to the DAC).
- sample_out_rdy  out  1  one-cycle pulse; outputs are valid from this cycle on.
- underrun  out  1  sticky; a segment boundary found no pending sample.
- overrun  out  1  sticky; a sample arrived while one was already pending.

## Operation
- **Reset values.** All outputs are 0. prev, cur, pending, acc, diff, phase k and div_cnt are all 0. The pending-valid flag pv is 0.
- **Divider.** div_cnt counts 0..OUT_DIV-1 and wraps. A *tick* is the cycle where div_cnt == OUT_DIV-1.
- **Input capture.** On `sample_in_rdy`: pending <= input and pv <= 1. If pv was already 1, the new sample overwrites pending and `overrun` is set.
- **On each tick:**
  - sample_out <= acc[RATIO_LOG2+17:RATIO_LOG2], taken before acc is updated.
  - acc <= acc + diff.
  - k <= k+1.
- **Segment wrap** (a tick with k == R-1):
  - k <= 0 and prev <= cur.
  - cur <= pending if pv, otherwise cur is held and `underrun` is set.
  - acc <= old_cur << RATIO_LOG2.
  - diff <= new_cur - old_cur.
  - pv <= 0.
  - `sample_req` pulses in the same cycle.
- **Output sequence.** For a segment (P, C), the outputs are P + floor(k·(C−P)/R) for k = 0..R-1. The shift is arithmetic, so results round toward −∞.
- **Widths.**
  - diff is 19-bit signed.
  - acc is (19+RATIO_LOG2)-bit signed.
  - Every output lies between P and C inclusive, so no saturation is needed.
- **Simultaneous strobe and wrap.** The strobed sample bypasses directly into cur. That is not underrun. It is overrun only if pv was already 1; in that case the strobed sample wins.
- **Post-reset request.** `sample_req` also pulses once on the first clock after reset deasserts.
- **Reset mid-operation.** Returns every register to its reset value immediately. Any pending sample is discarded.
- Flags clear only on reset.
- The two channels are fully independent apart from the shared k, div_cnt and pv.

## Timing
- First tick occurs OUT_DIV cycles after reset release. Ticks then repeat every OUT_DIV cycles exactly, regardless of input activity.
- `sample_out_rdy` is high in the cycle after the tick register update, i.e. aligned with the new sample_out values.
- `sample_req` period is R·OUT_DIV cycles. Upstream may answer anywhere before the next wrap, inclusive of the wrap cycle.
- Input-to-output latency: a sample strobed in segment n becomes C at wrap n. It is first output exactly (as k=0 of segment n+2) R·OUT_DIV cycles after that wrap.
- Throughput floor: OUT_DIV must be ≥ 8 so the downstream DAC's 8-cycle program completes between strobes.

## Structure
- Default RATIO_LOG2 and OUT_DIV go in globals.vh as `SDDAC_INTERP_RATIO_LOG2 and `SDDAC_INTERP_OUT_DIV.
- One sub-module, sddac_interp_channel, holds the per-channel datapath: prev, cur, pending, acc, diff and the output register. It is instantiated for L and R.
- The top holds div_cnt, k, pv, the handshake and the flags.

## Test plan
- **Reset and idle.** Reset, no input → `sample_req` at cycle 1. `sample_out_rdy` every 64 cycles with outputs 0. `underrun` set at the first wrap (cycle 512).
- **Ramp.** Answer the first request with L=0x00800, R=0x3F800 (−2048). Segment 1 → L = 0x000, 0x100, …, 0x700 and R = 0, −256, …, −1792. With no further input, segment 2 holds 0x00800 / −2048 and `underrun` is set.
- **Floor rounding.** prev=0, cur=−9 (0x3FFF7) → L outputs 0, −2, −3, −4, −5, −6, −7, −8.
- **Overrun.** Two strobes (0x01000, then 0x02000) in one segment → `overrun`=1. cur takes 0x02000 at the wrap.
- **Strobe on wrap cycle.** Strobe exactly on the wrap tick → sample used as cur, no underrun, `sample_req` still pulses.
- **Reset mid-segment.** Assert reset at k=4 → all outputs and flags are 0 the same cycle. Sequencing restarts with a `sample_req` one cycle after release.
